// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: default widths and load funct3 encodings.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // True for the five load encodings the extension unit understands.
  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as the writeback load queue.
// DEPTH must be a power of two (>=2) so the pointers wrap naturally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array: write the pushed entry at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1'b1);
        2'b01:   count_r <= count_r - (PW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers EX results (1-entry slot) and extended load data
// (FIFO), then issues at most one register-file write per cycle, loads first.
// Writes targeting x0 (or EX results with no rd write) are dropped at accept.
module wb_stage
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int LQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_wen,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic [1:0]            ld_addr_lo,
  input  logic [2:0]            ld_funct3,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic                  ld_err
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic                  ex_slot_full_r;
  logic [ADDR_WIDTH-1:0] ex_rd_r;
  logic [DATA_WIDTH-1:0] ex_data_r;
  logic                  rf_wen_r;
  logic [ADDR_WIDTH-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic                  ld_err_r;

  logic                  ld_accept_s;
  logic                  ex_accept_s;
  logic                  lq_push_s;
  logic                  ex_push_s;
  logic                  lq_pop_s;
  logic                  ex_pop_s;
  logic [7:0]            ld_byte_s;
  logic [15:0]           ld_half_s;
  logic [DATA_WIDTH-1:0] ld_ext_s;
  logic [EW-1:0]         lq_head_s;
  logic                  lq_full_s;
  logic                  lq_empty_s;
  logic [CW-1:0]         lq_count_s;

  // Ready depends only on buffer state so it never combinationally follows valid.
  assign ex_ready    = ~ex_slot_full_r;
  assign ld_ready    = ~lq_full_s;
  assign ld_accept_s = ld_valid & ld_ready;
  assign ex_accept_s = ex_valid & ex_ready;
  assign lq_push_s   = ld_accept_s & (ld_rd != {ADDR_WIDTH{1'b0}});
  assign ex_push_s   = ex_accept_s & ex_wen & (ex_rd != {ADDR_WIDTH{1'b0}});

  // Pick the byte/half addressed by the low offset bits, then extend per funct3.
  always_comb begin
    ld_byte_s = 8'h00;
    ld_half_s = 16'h0000;
    ld_ext_s  = ld_rdata;
    case (ld_addr_lo)
      2'd0:    ld_byte_s = ld_rdata[7:0];
      2'd1:    ld_byte_s = ld_rdata[15:8];
      2'd2:    ld_byte_s = ld_rdata[23:16];
      2'd3:    ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = ld_rdata[7:0];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
    case (ld_funct3)
      F3_LB:   ld_ext_s = {{(DATA_WIDTH-8){ld_byte_s[7]}}, ld_byte_s};
      F3_LH:   ld_ext_s = {{(DATA_WIDTH-16){ld_half_s[15]}}, ld_half_s};
      F3_LW:   ld_ext_s = ld_rdata;
      F3_LBU:  ld_ext_s = {{(DATA_WIDTH-8){1'b0}}, ld_byte_s};
      F3_LHU:  ld_ext_s = {{(DATA_WIDTH-16){1'b0}}, ld_half_s};
      default: ld_ext_s = ld_rdata;
    endcase
  end

  // Writeback source select: load queue head has fixed priority over the EX slot.
  always_comb begin
    lq_pop_s = 1'b0;
    ex_pop_s = 1'b0;
    if (!lq_empty_s) begin
      lq_pop_s = 1'b1;
    end else if (ex_slot_full_r) begin
      ex_pop_s = 1'b1;
    end else begin
      lq_pop_s = 1'b0;
      ex_pop_s = 1'b0;
    end
  end

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push_s),
    .push_data ({ld_rd, ld_ext_s}),
    .pop       (lq_pop_s),
    .pop_data  (lq_head_s),
    .full      (lq_full_s),
    .empty     (lq_empty_s),
    .count     (lq_count_s)
  );

  // EX holding slot: fill on an accepted writing result, drain when selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot_full_r <= 1'b0;
      ex_rd_r        <= {ADDR_WIDTH{1'b0}};
      ex_data_r      <= {DATA_WIDTH{1'b0}};
    end else if (ex_push_s) begin
      ex_slot_full_r <= 1'b1;
      ex_rd_r        <= ex_rd;
      ex_data_r      <= ex_data;
    end else if (ex_pop_s) begin
      ex_slot_full_r <= 1'b0;
    end
  end

  // Register-file write port: one-cycle pulse, address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= {ADDR_WIDTH{1'b0}};
      rf_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rf_wen_r <= lq_pop_s | ex_pop_s;
      if (lq_pop_s) begin
        {rf_waddr_r, rf_wdata_r} <= lq_head_s;
      end else if (ex_pop_s) begin
        rf_waddr_r <= ex_rd_r;
        rf_wdata_r <= ex_data_r;
      end
    end
  end

  // Sticky flag for any accepted load carrying an unsupported funct3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err_r <= 1'b0;
    end else if (ld_accept_s && !f3_legal(ld_funct3)) begin
      ld_err_r <= 1'b1;
    end
  end

  assign rf_wen   = rf_wen_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign ld_err   = ld_err_r;
  assign busy     = (lq_count_s != {CW{1'b0}}) | ex_slot_full_r | rf_wen_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback behaviour.
module tb_wb_stage;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LQ = 2;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_wen;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_rdata;
  logic [1:0]    ld_addr_lo;
  logic [2:0]    ld_funct3;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [AW-1:0] mq_rd [$];
  logic [DW-1:0] mq_data [$];
  bit            m_ex_pend;
  logic [AW-1:0] m_ex_rd;
  logic [DW-1:0] m_ex_data;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_err;

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LQ_DEPTH(LQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_rdata(ld_rdata),
    .ld_addr_lo(ld_addr_lo), .ld_funct3(ld_funct3),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load result per RISC-V rules, computed arithmetically on the raw word.
  function automatic logic [DW-1:0] ref_ext(input logic [DW-1:0] raw, input logic [1:0] lo,
                                            input logic [2:0] f3);
    logic [DW-1:0] b;
    logic [DW-1:0] h;
    logic [DW-1:0] r;
    int            hs;
    hs = (lo >= 2'd2) ? 16 : 0;
    b  = (raw >> (8 * int'(lo))) & 32'h0000_00FF;
    h  = (raw >> hs) & 32'h0000_FFFF;
    case (f3)
      3'd0:    r = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    r = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    r = b;
      3'd5:    r = h;
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  task automatic model_reset();
    mq_rd.delete();
    mq_data.delete();
    m_ex_pend = 1'b0;
    m_ex_rd   = '0;
    m_ex_data = '0;
    m_wen     = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_err     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit ldr;
    bit exr;
    ldr = (mq_rd.size() < LQ);
    exr = !m_ex_pend;
    if (mq_rd.size() > 0) begin
      m_wen   = 1'b1;
      m_waddr = mq_rd.pop_front();
      m_wdata = mq_data.pop_front();
    end else if (m_ex_pend) begin
      m_wen     = 1'b1;
      m_waddr   = m_ex_rd;
      m_wdata   = m_ex_data;
      m_ex_pend = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (ld_valid && ldr) begin
      if (!ref_legal(ld_funct3)) m_err = 1'b1;
      if (ld_rd != 5'd0) begin
        mq_rd.push_back(ld_rd);
        mq_data.push_back(ref_ext(ld_rdata, ld_addr_lo, ld_funct3));
      end
    end
    if (ex_valid && exr && ex_wen && ex_rd != 5'd0) begin
      m_ex_pend = 1'b1;
      m_ex_rd   = ex_rd;
      m_ex_data = ex_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_wen     = 1'b0;
    ex_rd      = 5'd0;
    ex_data    = 32'd0;
    ld_valid   = 1'b0;
    ld_rd      = 5'd0;
    ld_rdata   = 32'd0;
    ld_addr_lo = 2'd0;
    ld_funct3  = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rf_wen !== 1'b0)      begin n_bad++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0)    begin n_bad++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0)   begin n_bad++; $display("FAIL reset_rf_wdata got %08h want 0", rf_wdata); end
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (ld_err !== 1'b0)      begin n_bad++; $display("FAIL reset_ld_err got %0b want 0", ld_err); end
    n_cmp++; if (ex_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_ex_ready got %0b want 1", ex_ready); end
    n_cmp++; if (ld_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_ld_ready got %0b want 1", ld_ready); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ex_basic();
    ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    n_cmp++; if (rf_wen !== 1'b0)   begin n_bad++; $display("FAIL ex_accept_wen got %0b want 0", rf_wen); end
    n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL ex_accept_busy got %0b want 1", busy); end
    n_cmp++; if (ex_ready !== 1'b0) begin n_bad++; $display("FAIL ex_slot_ready got %0b want 0", ex_ready); end
    tick();
    n_cmp++; if (rf_wen !== 1'b1)          begin n_bad++; $display("FAIL ex_write_wen got %0b want 1", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd5)        begin n_bad++; $display("FAIL ex_write_addr got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ex_write_data got %08h want deadbeef", rf_wdata); end
    tick();
    n_cmp++; if (rf_wen !== 1'b0)   begin n_bad++; $display("FAIL ex_pulse_end got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_bad++; $display("FAIL ex_addr_hold got %0d want 5", rf_waddr); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL ex_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  t_f3  [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd2, 3'd0};
    logic [31:0] t_raw [7] = '{32'h0000_80FF, 32'h0000_80FF, 32'h8001_7F00, 32'h8001_7F00,
                               32'h8001_7F00, 32'hCAFE_BABE, 32'h1234_5678};
    logic [1:0]  t_lo  [7] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3};
    logic [4:0]  t_rd  [7] = '{5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd31, 5'd1};
    logic [31:0] t_exp [7] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_8001,
                               32'h0000_7F00, 32'hCAFE_BABE, 32'h0000_0012};
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_rd = t_rd[i]; ld_rdata = t_raw[i]; ld_addr_lo = t_lo[i]; ld_funct3 = t_f3[i];
      tick();
      idle_inputs();
      tick();
      n_cmp++; if (rf_wen !== 1'b1)      begin n_bad++; $display("FAIL ld_ext%0d_wen got %0b want 1", i, rf_wen); end
      n_cmp++; if (rf_waddr !== t_rd[i]) begin n_bad++; $display("FAIL ld_ext%0d_addr got %0d want %0d", i, rf_waddr, t_rd[i]); end
      n_cmp++; if (rf_wdata !== t_exp[i]) begin n_bad++; $display("FAIL ld_ext%0d_data got %08h want %08h", i, rf_wdata, t_exp[i]); end
    end
    tick();
    n_cmp++; if (ld_err !== 1'b0) begin n_bad++; $display("FAIL ld_ext_err got %0b want 0", ld_err); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen [$];
    logic [4:0] want [4] = '{5'd10, 5'd11, 5'd12, 5'd20};
    ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd20; ex_data = 32'h0000_00E0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_rdata = 32'h100 + 32'(i); ld_addr_lo = 2'd0; ld_funct3 = 3'd2;
      tick();
      if (rf_wen) seen.push_back(rf_waddr);
      n_cmp++; if (ld_ready !== (mq_rd.size() < LQ)) begin n_bad++; $display("FAIL b2b_ld_ready got %0b want %0b", ld_ready, mq_rd.size() < LQ); end
      n_cmp++; if (ex_ready !== !m_ex_pend) begin n_bad++; $display("FAIL b2b_ex_ready got %0b want %0b", ex_ready, !m_ex_pend); end
    end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rf_wen) seen.push_back(rf_waddr);
      n_cmp++; if (rf_wdata !== m_wdata) begin n_bad++; $display("FAIL b2b_data got %08h want %08h", rf_wdata, m_wdata); end
    end
    n_cmp++; if (seen.size() != 4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      n_cmp++; if (seen[i] !== want[i]) begin n_bad++; $display("FAIL b2b_order%0d got %0d want %0d", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_x0_drop();
    ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0; ex_data = 32'h0000_1234;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_rdata = 32'h5555_AAAA; ld_funct3 = 3'd2;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rf_wen !== 1'b0)   begin n_bad++; $display("FAIL x0_wen%0d got %0b want 0", i, rf_wen); end
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL x0_busy%0d got %0b want 0", i, busy); end
      n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ex_ready%0d got %0b want 1", i, ex_ready); end
      tick();
    end
  endtask

  task automatic test_illegal_funct3();
    ld_valid = 1'b1; ld_rd = 5'd6; ld_rdata = 32'h1122_3344; ld_addr_lo = 2'd1; ld_funct3 = 3'd3;
    tick();
    idle_inputs();
    n_cmp++; if (ld_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_set got %0b want 1", ld_err); end
    tick();
    n_cmp++; if (rf_wen !== 1'b1)           begin n_bad++; $display("FAIL illegal_wen got %0b want 1", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd6)         begin n_bad++; $display("FAIL illegal_addr got %0d want 6", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h11223344) begin n_bad++; $display("FAIL illegal_data got %08h want 11223344", rf_wdata); end
    ld_valid = 1'b1; ld_rd = 5'd7; ld_rdata = 32'h0000_0001; ld_funct3 = 3'd2;
    tick();
    idle_inputs();
    repeat (3) tick();
    n_cmp++; if (ld_err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_sticky got %0b want 1", ld_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ex_valid   = 1'($urandom_range(0, 1));
      ex_wen     = ($urandom_range(0, 7) != 0);
      ex_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ex_data    = 32'($urandom);
      ld_valid   = ($urandom_range(0, 2) != 0);
      ld_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_rdata   = 32'($urandom);
      ld_addr_lo = 2'($urandom_range(0, 3));
      ld_funct3  = 3'($urandom_range(0, 7));
      tick();
      n_cmp++; if (rf_wen !== m_wen)     begin n_bad++; $display("FAIL rnd%0d_wen got %0b want %0b", i, rf_wen, m_wen); end
      n_cmp++; if (rf_waddr !== m_waddr) begin n_bad++; $display("FAIL rnd%0d_addr got %0d want %0d", i, rf_waddr, m_waddr); end
      n_cmp++; if (rf_wdata !== m_wdata) begin n_bad++; $display("FAIL rnd%0d_data got %08h want %08h", i, rf_wdata, m_wdata); end
      n_cmp++; if (ld_err !== m_err)     begin n_bad++; $display("FAIL rnd%0d_err got %0b want %0b", i, ld_err, m_err); end
      n_cmp++; if (ld_ready !== (mq_rd.size() < LQ)) begin n_bad++; $display("FAIL rnd%0d_ld_ready got %0b want %0b", i, ld_ready, mq_rd.size() < LQ); end
      n_cmp++; if (ex_ready !== !m_ex_pend) begin n_bad++; $display("FAIL rnd%0d_ex_ready got %0b want %0b", i, ex_ready, !m_ex_pend); end
      n_cmp++; if (busy !== (mq_rd.size() != 0 || m_ex_pend || m_wen)) begin n_bad++; $display("FAIL rnd%0d_busy got %0b want %0b", i, busy, (mq_rd.size() != 0 || m_ex_pend || m_wen)); end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd12; ex_data = 32'hAAAA_0001;
    ld_valid = 1'b1; ld_rd = 5'd13; ld_rdata = 32'hBBBB_0002; ld_funct3 = 3'd3;
    tick();
    ex_valid = 1'b0;
    ld_rd = 5'd14; ld_funct3 = 3'd2;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_busy got %0b want 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0)    begin n_bad++; $display("FAIL midrst_wen got %0b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0)  begin n_bad++; $display("FAIL midrst_addr got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_bad++; $display("FAIL midrst_data got %08h want 0", rf_wdata); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
    n_cmp++; if (ld_err !== 1'b0)    begin n_bad++; $display("FAIL midrst_err got %0b want 0", ld_err); end
    n_cmp++; if (ld_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_ld_ready got %0b want 1", ld_ready); end
    n_cmp++; if (ex_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_ex_ready got %0b want 1", ex_ready); end
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL midrst_after_wen%0d got %0b want 0", i, rf_wen); end
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL midrst_after_busy%0d got %0b want 0", i, busy); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ex_basic();
    test_load_ext();
    test_back_to_back();
    test_x0_drop();
    test_illegal_funct3();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
